// File: rtl/rasterbar_scheduler_if.sv
// Bus between display timing, sine ROM and the rasterbar scheduler.
// Carries frame/line strobes, ROM port and the per-line bar result.
interface rasterbar_scheduler_if #(
    parameter int CORDW     = 16,
    parameter int SIN_ADDRW = 6,
    parameter int SIN_DATAW = 8,
    parameter int NBARS     = 4,
    parameter int BAR_H     = 40
);
    logic                        frame;
    logic                        line;
    logic signed [CORDW-1:0]     sy;
    logic [SIN_ADDRW-1:0]        rom_addr;
    logic signed [SIN_DATAW-1:0] rom_data;
    logic                        busy;
    logic                        bar_hit;
    logic [$clog2(NBARS)-1:0]    bar_id;
    logic [$clog2(BAR_H)-1:0]    bar_row;
    logic                        bar_up;

    modport master (
        output frame, line, sy, rom_data,
        input  rom_addr, busy, bar_hit, bar_id, bar_row, bar_up
    );

    modport slave (
        input  frame, line, sy, rom_data,
        output rom_addr, busy, bar_hit, bar_id, bar_row, bar_up
    );
endinterface

// File: rtl/rasterbar_scheduler.sv
// Per-frame bar position update over a shared sine ROM port and
// per-line serial front-to-back bar hit resolution.
module rasterbar_scheduler #(
    parameter int NBARS      = 4,
    parameter int CORDW      = 16,
    parameter int VCENTER    = 220,
    parameter int BAR_H      = 40,
    parameter int SIN_ADDRW  = 6,
    parameter int SIN_DATAW  = 8,
    parameter int SIN_SHIFT  = 1,
    parameter int PHASE_STEP = 1,
    parameter int BAR_PHASE  = 8
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    rasterbar_scheduler_if.slave bus
);
    localparam int IW = (NBARS > 1) ? $clog2(NBARS) : 1;
    localparam int RW = (BAR_H > 1) ? $clog2(BAR_H) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_STORE,
        S_COMMIT
    } state_t;

    state_t                  state_q;
    logic [SIN_ADDRW-1:0]    phase_q;
    logic [IW-1:0]           i_q;
    logic [SIN_ADDRW-1:0]    rom_addr_q;
    logic                    busy_q;
    logic signed [CORDW-1:0] y_q    [NBARS];
    logic signed [CORDW-1:0] sh_q   [NBARS];
    logic signed [CORDW-1:0] prev_q [NBARS];

    logic                    scan_q;
    logic                    pend_q;
    logic [IW-1:0]           j_q;
    logic signed [CORDW-1:0] sy_q;
    logic signed [CORDW-1:0] snap_y_q [NBARS];
    logic [NBARS-1:0]        snap_up_q;
    logic                    found_q;
    logic [IW-1:0]           win_id_q;
    logic [RW-1:0]           win_row_q;
    logic                    win_up_q;
    logic                    hit_q;
    logic [IW-1:0]           id_q;
    logic [RW-1:0]           row_q;
    logic                    up_q;

    logic [SIN_ADDRW-1:0]    addr_calc;
    logic signed [CORDW-1:0] rom_ext;
    logic signed [CORDW-1:0] sample_y;
    logic signed [CORDW:0]   diff;
    logic                    hit_j;

    // ROM address for bar i, sample to bar y, and the current bar's hit test
    always_comb begin
        addr_calc = phase_q + SIN_ADDRW'(32'(i_q) * BAR_PHASE);
        rom_ext   = {{(CORDW-SIN_DATAW){bus.rom_data[SIN_DATAW-1]}},
                     bus.rom_data};
        sample_y  = CORDW'(VCENTER) + (rom_ext >>> SIN_SHIFT);
        diff      = {sy_q[CORDW-1], sy_q}
                  - {snap_y_q[j_q][CORDW-1], snap_y_q[j_q]};
        hit_j     = !diff[CORDW] && (diff < (CORDW+1)'(BAR_H));
    end

    // Update FSM: fetch one sample per bar into shadow, then commit all at once
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            i_q        <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b0;
            for (int k = 0; k < NBARS; k++) begin
                y_q[k]    <= CORDW'(VCENTER);
                sh_q[k]   <= CORDW'(VCENTER);
                prev_q[k] <= CORDW'(VCENTER);
            end
        end else if (bus.frame) begin
            // A frame mid-update drops the shadow and starts over
            phase_q <= phase_q + SIN_ADDRW'(PHASE_STEP);
            i_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADDR;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ADDR: begin
                    rom_addr_q <= addr_calc;
                    state_q    <= S_WAIT;
                end
                S_WAIT: state_q <= S_STORE;
                S_STORE: begin
                    sh_q[i_q] <= sample_y;
                    if (i_q == IW'(NBARS-1)) begin
                        state_q <= S_COMMIT;
                    end else begin
                        i_q     <= i_q + IW'(1);
                        state_q <= S_ADDR;
                    end
                end
                S_COMMIT: begin
                    for (int k = 0; k < NBARS; k++) begin
                        prev_q[k] <= y_q[k];
                        y_q[k]    <= sh_q[k];
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line scan: snapshot committed y at line, test one bar per cycle
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            scan_q    <= 1'b0;
            pend_q    <= 1'b0;
            j_q       <= '0;
            sy_q      <= '0;
            snap_up_q <= '0;
            found_q   <= 1'b0;
            win_id_q  <= '0;
            win_row_q <= '0;
            win_up_q  <= 1'b0;
            hit_q     <= 1'b0;
            id_q      <= '0;
            row_q     <= '0;
            up_q      <= 1'b0;
            for (int k = 0; k < NBARS; k++) begin
                snap_y_q[k] <= CORDW'(VCENTER);
            end
        end else begin
            if (pend_q) begin
                pend_q <= 1'b0;
                hit_q  <= found_q;
                id_q   <= found_q ? win_id_q : '0;
                row_q  <= found_q ? win_row_q : '0;
                up_q   <= found_q & win_up_q;
            end
            if (bus.line) begin
                // Snapshot keeps a same-cycle commit out of this scan
                sy_q    <= bus.sy;
                j_q     <= '0;
                scan_q  <= 1'b1;
                found_q <= 1'b0;
                for (int k = 0; k < NBARS; k++) begin
                    snap_y_q[k]  <= y_q[k];
                    snap_up_q[k] <= y_q[k] < prev_q[k];
                end
            end else if (scan_q) begin
                if (hit_j && !found_q) begin
                    found_q   <= 1'b1;
                    win_id_q  <= j_q;
                    win_row_q <= RW'(diff);
                    win_up_q  <= snap_up_q[j_q];
                end
                if (j_q == IW'(NBARS-1)) begin
                    scan_q <= 1'b0;
                    pend_q <= 1'b1;
                end else begin
                    j_q <= j_q + IW'(1);
                end
            end
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.busy     = busy_q;
    assign bus.bar_hit  = hit_q;
    assign bus.bar_id   = id_q;
    assign bus.bar_row  = row_q;
    assign bus.bar_up   = up_q;
endmodule

// File: tb/tb_rasterbar_scheduler.sv
// Bench for rasterbar_scheduler: synchronous ROM model plus a
// frame/line-level reference of bar positions and scan results.
module tb_rasterbar_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rasterbar_scheduler_if bus ();

    rasterbar_scheduler dut (
        .clk_pix  (clk),
        .rst_pix_n(rst_n),
        .bus      (bus)
    );

    logic signed [7:0] rom_tbl [64];
    always @(posedge clk) bus.rom_data <= rom_tbl[bus.rom_addr];

    int n_tests = 0;
    int n_fail  = 0;
    int pb_m;
    int y_m    [4];
    int prev_m [4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input int v);
        for (int a = 0; a < 64; a++) rom_tbl[a] = 8'(v);
    endtask

    task automatic model_reset;
        pb_m = 0;
        for (int k = 0; k < 4; k++) begin
            y_m[k]    = 220;
            prev_m[k] = 220;
        end
    endtask

    // One completed frame: advance phase, read every bar's sample
    task automatic model_frame;
        int ny [4];
        pb_m = (pb_m + 1) % 64;
        for (int k = 0; k < 4; k++)
            ny[k] = 220 + (int'(rom_tbl[(pb_m + 8 * k) % 64]) >>> 1);
        for (int k = 0; k < 4; k++) begin
            prev_m[k] = y_m[k];
            y_m[k]    = ny[k];
        end
    endtask

    // Front-most bar covering s wins; {hit, id, row, up}
    task automatic exp_scan(input int s, output logic [9:0] w);
        w = '0;
        for (int k = 0; k < 4; k++)
            if (!w[9] && y_m[k] <= s && s < y_m[k] + 40)
                w = {1'b1, 2'(k), 6'(s - y_m[k]), y_m[k] < prev_m[k]};
    endtask

    function automatic logic [9:0] got_res();
        return {bus.bar_hit, bus.bar_id, bus.bar_row, bus.bar_up};
    endfunction

    task automatic pulse_frame;
        bus.frame = 1'b1;
        tick();
        bus.frame = 1'b0;
    endtask

    task automatic pulse_line(input int s);
        bus.sy   = 16'(s);
        bus.line = 1'b1;
        tick();
        bus.line = 1'b0;
    endtask

    task automatic frame_commit;
        pulse_frame();
        model_frame();
        repeat (13) tick();
    endtask

    task automatic test_reset;
        logic [9:0] g;
        rst_n = 1'b0;
        repeat (2) tick();
        g = got_res();
        n_tests++;
        if (bus.rom_addr !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr);
        end
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_tests++;
        if (g !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_result got %h want 000", g);
        end
        rst_n = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic test_zero_rom;
        logic [9:0] w;
        fill_rom(0);
        pulse_frame();
        model_frame();
        repeat (12) tick();
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_at_12 got %b want 1", bus.busy);
        end
        tick();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_13 got %b want 0", bus.busy);
        end
        pulse_line(230);
        repeat (4) tick();
        n_tests++;
        if (bus.bar_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_early got %b want 0", bus.bar_hit);
        end
        tick();
        exp_scan(230, w);
        n_tests++;
        if (got_res() !== w || w !== {1'b1, 2'd0, 6'd10, 1'b0}) begin
            n_fail++;
            $display("FAIL scan_230 got %h want %h", got_res(), w);
        end
    endtask

    task automatic test_bar0_offset;
        int sys [3] = '{205, 245, 260};
        logic [9:0] w;
        fill_rom(0);
        rom_tbl[(pb_m + 1) % 64] = -8'sd40;
        frame_commit();
        foreach (sys[n]) begin
            pulse_line(sys[n]);
            repeat (5) tick();
            exp_scan(sys[n], w);
            n_tests++;
            if (got_res() !== w) begin
                n_fail++;
                $display("FAIL bar0_sy%0d got %h want %h",
                         sys[n], got_res(), w);
            end
        end
    endtask

    task automatic test_rom_addr;
        int want;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        model_reset();
        fill_rom(0);
        for (int f = 1; f <= 63; f++) begin
            pulse_frame();
            model_frame();
            for (int k = 0; k < 4; k++) begin
                repeat (k == 0 ? 1 : 3) tick();
                want = (pb_m + 8 * k) % 64;
                n_tests++;
                if (bus.rom_addr !== 6'(want)) begin
                    n_fail++;
                    $display("FAIL rom_addr f%0d b%0d got %0d want %0d",
                             f, k, bus.rom_addr, want);
                end
                if (f == 63 && k == 3) begin
                    n_tests++;
                    if (bus.rom_addr !== 6'd23) begin
                        n_fail++;
                        $display("FAIL rom_addr_f63 got %0d want 23",
                                 bus.rom_addr);
                    end
                end
            end
            repeat (3) tick();
        end
    endtask

    task automatic test_abort;
        int pb0;
        logic [9:0] w;
        fill_rom(0);
        frame_commit();
        pb0 = pb_m;
        rom_tbl[(pb0 + 1) % 64] = -8'sd40;
        pulse_frame();
        repeat (4) tick();
        pulse_frame();
        tick();
        n_tests++;
        if (bus.rom_addr !== 6'((pb0 + 2) % 64)) begin
            n_fail++;
            $display("FAIL abort_addr got %0d want %0d",
                     bus.rom_addr, (pb0 + 2) % 64);
        end
        repeat (7) tick();
        pulse_line(205);
        repeat (3) tick();
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_12 got %b want 1", bus.busy);
        end
        tick();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy_13 got %b want 0", bus.busy);
        end
        tick();
        exp_scan(205, w);
        n_tests++;
        if (got_res() !== w) begin
            n_fail++;
            $display("FAIL abort_nocommit got %h want %h", got_res(), w);
        end
        pb_m = (pb_m + 1) % 64;
        model_frame();
        pulse_line(230);
        repeat (5) tick();
        exp_scan(230, w);
        n_tests++;
        if (got_res() !== w) begin
            n_fail++;
            $display("FAIL abort_after got %h want %h", got_res(), w);
        end
    endtask

    task automatic test_bar_up;
        logic [9:0] w1;
        logic [9:0] w2;
        fill_rom(0);
        rom_tbl[(pb_m + 1 + 8) % 64] = -8'sd20;
        frame_commit();
        pulse_line(215);
        repeat (5) tick();
        exp_scan(215, w1);
        n_tests++;
        if (got_res() !== w1 || w1 !== {1'b1, 2'd1, 6'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL bar_up got %h want %h", got_res(), w1);
        end
        pulse_line(260);
        tick();
        pulse_line(225);
        repeat (3) tick();
        n_tests++;
        if (got_res() !== w1) begin
            n_fail++;
            $display("FAIL restart_hold got %h want %h", got_res(), w1);
        end
        repeat (2) tick();
        exp_scan(225, w2);
        n_tests++;
        if (got_res() !== w2) begin
            n_fail++;
            $display("FAIL restart_second got %h want %h", got_res(), w2);
        end
    endtask

    task automatic test_random;
        int k;
        int s;
        int s2;
        int rest;
        logic [9:0] w;
        for (int it = 0; it < 24; it++) begin
            for (int a = 0; a < 64; a++)
                rom_tbl[a] = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 20);
            s = $urandom_range(150, 300);
            if (k <= 13) exp_scan(s, w);
            if (k == 0) begin
                bus.sy    = 16'(s);
                bus.frame = 1'b1;
                bus.line  = 1'b1;
                tick();
                bus.frame = 1'b0;
                bus.line  = 1'b0;
            end else begin
                pulse_frame();
                repeat (k - 1) tick();
                pulse_line(s);
            end
            model_frame();
            if (k > 13) exp_scan(s, w);
            rest = ((k + 5) > 13 ? (k + 5) : 13) - k;
            repeat (rest) tick();
            n_tests++;
            if (got_res() !== w) begin
                n_fail++;
                $display("FAIL rand_it%0d k%0d sy%0d got %h want %h",
                         it, k, s, got_res(), w);
            end
            s2 = $urandom_range(150, 300);
            pulse_line(s2);
            repeat (5) tick();
            exp_scan(s2, w);
            n_tests++;
            if (got_res() !== w) begin
                n_fail++;
                $display("FAIL rand_post_it%0d sy%0d got %h want %h",
                         it, s2, got_res(), w);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] w;
        fill_rom(0);
        rom_tbl[(pb_m + 1) % 64] = -8'sd40;
        frame_commit();
        pulse_line(230);
        repeat (5) tick();
        exp_scan(230, w);
        n_tests++;
        if (got_res() !== w) begin
            n_fail++;
            $display("FAIL pre_reset got %h want %h", got_res(), w);
        end
        fill_rom(0);
        pulse_frame();
        repeat (3) tick();
        pulse_line(240);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.rom_addr, bus.busy, got_res()} !== 17'd0) begin
            n_fail++;
            $display("FAIL async_reset got addr%0d busy%b res%h want 0",
                     bus.rom_addr, bus.busy, got_res());
        end
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_line(225);
        repeat (5) tick();
        exp_scan(225, w);
        n_tests++;
        if (got_res() !== w) begin
            n_fail++;
            $display("FAIL post_reset_y got %h want %h", got_res(), w);
        end
        pulse_frame();
        model_frame();
        tick();
        n_tests++;
        if (bus.rom_addr !== 6'd1) begin
            n_fail++;
            $display("FAIL post_reset_addr got %0d want 1", bus.rom_addr);
        end
        repeat (12) tick();
    endtask

    initial begin
        bus.frame = 1'b0;
        bus.line  = 1'b0;
        bus.sy    = '0;
        fill_rom(0);
        model_reset();
        test_reset();
        test_zero_rom();
        test_bar0_offset();
        test_rom_addr();
        test_abort();
        test_bar_up();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
